// File: rtl/iob_spi_flash_sched.sv
// ----------------------------------------------------------------------------
// iob_spi_flash_sched
// Round-robin request scheduler in front of the SPI flash core. It shares the
// core's single command port between the cache read port and the software
// CSR command path, sequences each transaction through the core's
// valid/ready handshake and returns the result to the requester that issued it.
//
// Optional feature macro: SPI_SCHED_TIMEOUT_EN
//   defined   : TIMEOUT_W-bit watchdog on the core wait states. On expiry the
//               owner gets an all-ones result and timeout_o is set (sticky
//               until the next ISSUE).
//   undefined : waits are unbounded and timeout_o is tied low.
//
// Ports
//   clk_i, rst_n_i                       clock, synchronous active-low reset
//   cache_valid_i/addr_i                 cache read request (held until accepted)
//   cache_ready_o/rvalid_o/rdata_o       cache accept pulse, response pulse, data
//   sw_valid_i/address_i/datain_i/
//   command_i/commandtp_i                software command request
//   sw_ready_o/done_o/dataout_o          software accept pulse, completion, data
//   fl_valid_o/address_o/datain_o/
//   command_o/commandtp_o                command port to the core
//   fl_ready_i/dataout_i                 core idle/done flag and result data
//   busy_o                               scheduler not in IDLE
//   owner_o                              current or last grant (0 cache, 1 sw)
//   timeout_o                            sticky watchdog flag
// ----------------------------------------------------------------------------
module iob_spi_flash_sched #(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned ADDR_W          = 24,
    parameter logic [31:0] CACHE_COMMAND   = 32'h0000_2003,
    parameter logic [31:0] CACHE_COMMANDTP = 32'h0000_0000,
    parameter int unsigned TIMEOUT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    // cache read port
    input  logic              cache_valid_i,
    input  logic [ADDR_W-1:0] cache_addr_i,
    output logic              cache_ready_o,
    output logic              cache_rvalid_o,
    output logic [DATA_W-1:0] cache_rdata_o,
    // software command port
    input  logic              sw_valid_i,
    input  logic [31:0]       sw_address_i,
    input  logic [DATA_W-1:0] sw_datain_i,
    input  logic [31:0]       sw_command_i,
    input  logic [31:0]       sw_commandtp_i,
    output logic              sw_ready_o,
    output logic              sw_done_o,
    output logic [DATA_W-1:0] sw_dataout_o,
    // flash core command port
    output logic              fl_valid_o,
    output logic [31:0]       fl_address_o,
    output logic [DATA_W-1:0] fl_datain_o,
    output logic [31:0]       fl_command_o,
    output logic [31:0]       fl_commandtp_o,
    input  logic              fl_ready_i,
    input  logic [DATA_W-1:0] fl_dataout_i,
    // status
    output logic              busy_o,
    output logic              owner_o,
    output logic              timeout_o
);

    // Cache addresses are zero-extended into a 32-bit field; a watchdog needs
    // at least two counter bits to have a meaningful all-ones terminal count.
    if (ADDR_W > 32 || ADDR_W == 0 || TIMEOUT_W < 2) begin : g_bad_params
        $error("iob_spi_flash_sched: unsupported ADDR_W/TIMEOUT_W");
    end

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_RESP       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic              owner_q, owner_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] datain_q, datain_d;
    logic [31:0]       cmd_q, cmd_d;
    logic [31:0]       cmdtp_q, cmdtp_d;
    logic              fl_valid_q, fl_valid_d;
    logic              cache_ready_q, cache_ready_d;
    logic              sw_ready_q, sw_ready_d;
    logic              cache_rvalid_q, cache_rvalid_d;
    logic              sw_done_q, sw_done_d;
    logic [DATA_W-1:0] cache_rdata_q, cache_rdata_d;
    logic [DATA_W-1:0] sw_dataout_q, sw_dataout_d;
    logic              busy_q, busy_d;

    // Arbitration winner and end-of-transaction strobe (combinational helpers)
    logic              win;
    logic              finish;
    logic [DATA_W-1:0] finish_data;

`ifdef SPI_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    // Next-state, holding-register and registered-output logic
    always_comb begin
        state_d        = state_q;
        last_owner_d   = last_owner_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        datain_d       = datain_q;
        cmd_d          = cmd_q;
        cmdtp_d        = cmdtp_q;
        cache_rdata_d  = cache_rdata_q;
        sw_dataout_d   = sw_dataout_q;
        fl_valid_d     = 1'b0;
        cache_ready_d  = 1'b0;
        sw_ready_d     = 1'b0;
        cache_rvalid_d = 1'b0;
        sw_done_d      = 1'b0;
        win            = 1'b0;
        finish         = 1'b0;
        finish_data    = '0;
`ifdef SPI_SCHED_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        timeout_d      = timeout_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (cache_valid_i || sw_valid_i) begin
                    // A tie goes to whoever was not granted last time.
                    win          = (cache_valid_i && sw_valid_i) ? ~last_owner_q : sw_valid_i;
                    last_owner_d = win;
                    owner_d      = win;
                    if (win) begin
                        addr_d   = sw_address_i;
                        datain_d = sw_datain_i;
                        cmd_d    = sw_command_i;
                        cmdtp_d  = sw_commandtp_i;
                    end else begin
                        addr_d   = 32'(cache_addr_i);
                        datain_d = '0;
                        cmd_d    = CACHE_COMMAND;
                        cmdtp_d  = CACHE_COMMANDTP;
                    end
                    // Outputs are registered, so the ISSUE-cycle pulses are
                    // loaded on the transition into ISSUE.
                    fl_valid_d    = 1'b1;
                    cache_ready_d = ~win;
                    sw_ready_d    = win;
`ifdef SPI_SCHED_TIMEOUT_EN
                    timeout_d     = 1'b0;
`endif
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef SPI_SCHED_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!fl_ready_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (fl_ready_i) begin
                    finish      = 1'b1;
                    finish_data = fl_dataout_i;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SPI_SCHED_TIMEOUT_EN
        // Watchdog: expires when the incremented count reaches all-ones,
        // unless the core completed in the same cycle.
        if (state_q == S_WAIT_START || state_q == S_WAIT_DONE) begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
            if (!finish && (&tmo_cnt_d)) begin
                finish      = 1'b1;
                finish_data = '1;
                timeout_d   = 1'b1;
            end
        end
`endif

        // Route the result and the response pulse to the owner.
        if (finish) begin
            state_d = S_RESP;
            if (owner_q) begin
                sw_done_d    = 1'b1;
                sw_dataout_d = finish_data;
            end else begin
                cache_rvalid_d = 1'b1;
                cache_rdata_d  = finish_data;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= S_IDLE;
            last_owner_q   <= 1'b1;
            owner_q        <= 1'b0;
            addr_q         <= '0;
            datain_q       <= '0;
            cmd_q          <= '0;
            cmdtp_q        <= '0;
            fl_valid_q     <= 1'b0;
            cache_ready_q  <= 1'b0;
            sw_ready_q     <= 1'b0;
            cache_rvalid_q <= 1'b0;
            sw_done_q      <= 1'b0;
            cache_rdata_q  <= '0;
            sw_dataout_q   <= '0;
            busy_q         <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            datain_q       <= datain_d;
            cmd_q          <= cmd_d;
            cmdtp_q        <= cmdtp_d;
            fl_valid_q     <= fl_valid_d;
            cache_ready_q  <= cache_ready_d;
            sw_ready_q     <= sw_ready_d;
            cache_rvalid_q <= cache_rvalid_d;
            sw_done_q      <= sw_done_d;
            cache_rdata_q  <= cache_rdata_d;
            sw_dataout_q   <= sw_dataout_d;
            busy_q         <= busy_d;
`ifdef SPI_SCHED_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    assign cache_ready_o  = cache_ready_q;
    assign cache_rvalid_o = cache_rvalid_q;
    assign cache_rdata_o  = cache_rdata_q;
    assign sw_ready_o     = sw_ready_q;
    assign sw_done_o      = sw_done_q;
    assign sw_dataout_o   = sw_dataout_q;
    assign fl_valid_o     = fl_valid_q;
    assign fl_address_o   = addr_q;
    assign fl_datain_o    = datain_q;
    assign fl_command_o   = cmd_q;
    assign fl_commandtp_o = cmdtp_q;
    assign busy_o         = busy_q;
    assign owner_o        = owner_q;
`ifdef SPI_SCHED_TIMEOUT_EN
    assign timeout_o      = timeout_q;
`else
    assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_iob_spi_flash_sched.sv
// ----------------------------------------------------------------------------
// tb_iob_spi_flash_sched
// Scoreboard bench for iob_spi_flash_sched. Expected transactions are queued
// when a request is driven; a negedge monitor pops them on each accept pulse
// and checks the response, its timing and the stability of the fl_* port.
// A small behavioural core model drives fl_ready_i / fl_dataout_i.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iob_spi_flash_sched;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 24;
`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W  = 4;
`else
    localparam int unsigned TMO_W  = 16;
`endif
    localparam logic [31:0] CACHE_CMD   = 32'h0000_2003;
    localparam logic [31:0] CACHE_CMDTP = 32'h0000_0000;

    logic              clk;
    logic              rst_n_i;
    logic              cache_valid_i;
    logic [ADDR_W-1:0] cache_addr_i;
    logic              cache_ready_o, cache_rvalid_o;
    logic [DATA_W-1:0] cache_rdata_o;
    logic              sw_valid_i;
    logic [31:0]       sw_address_i, sw_command_i, sw_commandtp_i;
    logic [DATA_W-1:0] sw_datain_i;
    logic              sw_ready_o, sw_done_o;
    logic [DATA_W-1:0] sw_dataout_o;
    logic              fl_valid_o;
    logic [31:0]       fl_address_o, fl_command_o, fl_commandtp_o;
    logic [DATA_W-1:0] fl_datain_o;
    logic              fl_ready_i;
    logic [DATA_W-1:0] fl_dataout_i;
    logic              busy_o, owner_o, timeout_o;

    iob_spi_flash_sched #(
        .DATA_W          (DATA_W),
        .ADDR_W          (ADDR_W),
        .CACHE_COMMAND   (CACHE_CMD),
        .CACHE_COMMANDTP (CACHE_CMDTP),
        .TIMEOUT_W       (TMO_W)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n_i),
        .cache_valid_i  (cache_valid_i),
        .cache_addr_i   (cache_addr_i),
        .cache_ready_o  (cache_ready_o),
        .cache_rvalid_o (cache_rvalid_o),
        .cache_rdata_o  (cache_rdata_o),
        .sw_valid_i     (sw_valid_i),
        .sw_address_i   (sw_address_i),
        .sw_datain_i    (sw_datain_i),
        .sw_command_i   (sw_command_i),
        .sw_commandtp_i (sw_commandtp_i),
        .sw_ready_o     (sw_ready_o),
        .sw_done_o      (sw_done_o),
        .sw_dataout_o   (sw_dataout_o),
        .fl_valid_o     (fl_valid_o),
        .fl_address_o   (fl_address_o),
        .fl_datain_o    (fl_datain_o),
        .fl_command_o   (fl_command_o),
        .fl_commandtp_o (fl_commandtp_o),
        .fl_ready_i     (fl_ready_i),
        .fl_dataout_i   (fl_dataout_i),
        .busy_o         (busy_o),
        .owner_o        (owner_o),
        .timeout_o      (timeout_o)
    );

    typedef struct {
        logic        owner;
        logic [31:0] addr;
        logic [31:0] datain;
        logic [31:0] cmd;
        logic [31:0] cmdtp;
        logic [31:0] data;
        logic        resp;
        logic        tmo;
        int          resp_off;   // 0: response one cycle after core ready rises
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] core_q[$];
    txn_t        cur;
    logic        in_flight;
    int          cyc;
    int          acc_cyc;
    int          rise_cyc;
    int          core_mode;      // 0 normal, 1 never drops ready, 2 holds low 40 cycles
    int          core_lat;
    int          n_cmp;
    int          n_err;
    int          n_resp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"},
                 128'({cache_ready_o, cache_rvalid_o, sw_ready_o, sw_done_o,
                       fl_valid_o, busy_o, owner_o, timeout_o}), 128'(0));
        check_eq({tag, "_data"},
                 {cache_rdata_o, sw_dataout_o, fl_address_o, fl_datain_o}, 128'(0));
        check_eq({tag, "_cmd"}, 128'({fl_command_o, fl_commandtp_o}), 128'(0));
    endtask

    task automatic push_txn(input logic owner, input logic [31:0] addr, input logic [31:0] datain,
                            input logic [31:0] cmd, input logic [31:0] cmdtp, input logic [31:0] data,
                            input logic resp, input logic tmo, input int resp_off);
        txn_t t;
        t.owner    = owner;
        t.addr     = addr;
        t.datain   = datain;
        t.cmd      = cmd;
        t.cmdtp    = cmdtp;
        t.data     = data;
        t.resp     = resp;
        t.tmo      = tmo;
        t.resp_off = resp_off;
        exp_q.push_back(t);
    endtask

    // Drive one request, hold it until accepted, then drop it.
    task automatic req(input logic owner, input logic [31:0] addr, input logic [31:0] datain,
                       input logic [31:0] cmd, input logic [31:0] cmdtp);
        int   dcyc;
        logic got;
        @(posedge clk);
        #1;
        if (owner) begin
            sw_address_i   = addr;
            sw_datain_i    = datain;
            sw_command_i   = cmd;
            sw_commandtp_i = cmdtp;
            sw_valid_i     = 1'b1;
        end else begin
            cache_addr_i   = ADDR_W'(addr);
            cache_valid_i  = 1'b1;
        end
        dcyc = cyc;
        got  = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = owner ? sw_ready_o : cache_ready_o;
        end
        if (got) check_eq("accept_latency", 128'(cyc - dcyc), 128'(1));
        else     check_eq("accept_wait", 128'(got), 128'(1));
        @(posedge clk);
        #1;
        cache_valid_i = 1'b0;
        sw_valid_i    = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 300 && n_resp < target; i++) @(posedge clk);
        check_eq("resp_count", 128'(n_resp), 128'(target));
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 rst_n_i = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_n_i = 1'b1;
        in_flight = 1'b0;
    endtask

    // Behavioural flash core: drops ready the cycle after the start pulse,
    // keeps it low for core_lat cycles, then raises it with the next result.
    initial begin
        fl_ready_i   = 1'b1;
        fl_dataout_i = '0;
        forever begin
            @(negedge clk);
            if (fl_valid_o && rst_n_i && core_mode != 1) begin
                @(posedge clk);
                #1 fl_ready_i = 1'b0;
                repeat (core_mode == 2 ? 40 : core_lat) @(posedge clk);
                #1;
                if (core_q.size() != 0) fl_dataout_i = core_q.pop_front();
                else                    fl_dataout_i = 32'hBAD0_BAD0;
                fl_ready_i = 1'b1;
                rise_cyc   = cyc;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        in_flight = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n_i) begin
                if (cache_ready_o || sw_ready_o) begin
                    check_eq("dual_accept", 128'(cache_ready_o & sw_ready_o), 128'(0));
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_accept", 128'(cache_ready_o | sw_ready_o), 128'(0));
                    end else begin
                        cur       = exp_q.pop_front();
                        acc_cyc   = cyc;
                        in_flight = 1'b1;
                        check_eq("accept_owner", 128'(sw_ready_o), 128'(cur.owner));
                        check_eq("owner_o", 128'(owner_o), 128'(cur.owner));
                        check_eq("fl_valid_at_accept", 128'(fl_valid_o), 128'(1));
                        check_eq("timeout_at_issue", 128'(timeout_o), 128'(0));
                    end
                end else begin
                    check_eq("stray_fl_valid", 128'(fl_valid_o), 128'(0));
                end

                if (in_flight)
                    check_eq("fl_hold", {fl_address_o, fl_datain_o, fl_command_o, fl_commandtp_o},
                             {cur.addr, cur.datain, cur.cmd, cur.cmdtp});

                if (cache_rvalid_o || sw_done_o) begin
                    check_eq("dual_resp", 128'(cache_rvalid_o & sw_done_o), 128'(0));
                    if (!in_flight || !cur.resp) begin
                        check_eq("unexpected_resp", 128'(cache_rvalid_o | sw_done_o), 128'(0));
                    end else begin
                        check_eq("resp_owner", 128'(sw_done_o), 128'(cur.owner));
                        check_eq("resp_data", 128'(sw_done_o ? sw_dataout_o : cache_rdata_o), 128'(cur.data));
                        check_eq("resp_timeout", 128'(timeout_o), 128'(cur.tmo));
                        if (cur.resp_off != 0) check_eq("resp_cycle", 128'(cyc), 128'(acc_cyc + cur.resp_off));
                        else                   check_eq("resp_cycle", 128'(cyc), 128'(rise_cyc + 1));
                        n_resp++;
                    end
                    in_flight = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; n_resp = 0;
        rst_n_i = 1'b0;
        cache_valid_i = 1'b0; cache_addr_i = '0;
        sw_valid_i = 1'b0; sw_address_i = '0; sw_datain_i = '0;
        sw_command_i = '0; sw_commandtp_i = '0;
        core_mode = 0; core_lat = 3; rise_cyc = 0; acc_cyc = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        @(posedge clk);
        #1 rst_n_i = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        // Cache read, core busy for 10 cycles
        core_lat = 10;
        core_q.push_back(32'h1234_5678);
        push_txn(1'b0, 32'h0000_ABCD, 32'h0, CACHE_CMD, CACHE_CMDTP, 32'h1234_5678, 1'b1, 1'b0, 0);
        req(1'b0, 32'h0000_ABCD, 32'h0, 32'h0, 32'h0);
        wait_resp(1);

        // Software write
        core_lat = 4;
        core_q.push_back(32'hCAFE_0006);
        push_txn(1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0000_0006, 32'h0000_0011, 32'hCAFE_0006, 1'b1, 1'b0, 0);
        req(1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0000_0006, 32'h0000_0011);
        wait_resp(2);
        @(negedge clk);
        check_eq("sw_dataout_hold", 128'(sw_dataout_o), 128'(32'hCAFE_0006));

        // Minimum latency, top cache address
        core_lat = 1;
        core_q.push_back(32'h8000_0001);
        push_txn(1'b0, 32'h00FF_FFFF, 32'h0, CACHE_CMD, CACHE_CMDTP, 32'h8000_0001, 1'b1, 1'b0, 0);
        req(1'b0, 32'h00FF_FFFF, 32'h0, 32'h0, 32'h0);
        wait_resp(3);

        // Both requesters held after reset: cache, sw, cache, sw
        do_reset(2);
        core_lat = 3;
        core_q.push_back(32'h0000_0011);
        core_q.push_back(32'h0000_0022);
        core_q.push_back(32'h0000_0033);
        core_q.push_back(32'h0000_0044);
        push_txn(1'b0, 32'h0000_0010, 32'h0, CACHE_CMD, CACHE_CMDTP, 32'h0000_0011, 1'b1, 1'b0, 0);
        push_txn(1'b1, 32'h0000_2000, 32'h0000_0005, 32'h0000_000B, 32'h0000_0001, 32'h0000_0022, 1'b1, 1'b0, 0);
        push_txn(1'b0, 32'h0000_0010, 32'h0, CACHE_CMD, CACHE_CMDTP, 32'h0000_0033, 1'b1, 1'b0, 0);
        push_txn(1'b1, 32'h0000_2000, 32'h0000_0005, 32'h0000_000B, 32'h0000_0001, 32'h0000_0044, 1'b1, 1'b0, 0);
        @(posedge clk);
        #1;
        cache_addr_i   = 24'h00_0010;
        sw_address_i   = 32'h0000_2000;
        sw_datain_i    = 32'h0000_0005;
        sw_command_i   = 32'h0000_000B;
        sw_commandtp_i = 32'h0000_0001;
        cache_valid_i  = 1'b1;
        sw_valid_i     = 1'b1;
        begin
            int n_sw;
            n_sw = 0;
            for (int i = 0; i < 400 && n_sw < 2; i++) begin
                @(negedge clk);
                if (sw_ready_o) n_sw++;
            end
            check_eq("held_sw_grants", 128'(n_sw), 128'(2));
        end
        @(posedge clk);
        #1;
        cache_valid_i = 1'b0;
        sw_valid_i    = 1'b0;
        wait_resp(7);

`ifdef SPI_SCHED_TIMEOUT_EN
        // Watchdog: core holds ready low far longer than the timeout
        core_mode = 2;
        push_txn(1'b0, 32'h0000_0042, 32'h0, CACHE_CMD, CACHE_CMDTP, 32'hFFFF_FFFF, 1'b1, 1'b1, 16);
        req(1'b0, 32'h0000_0042, 32'h0, 32'h0, 32'h0);
        wait_resp(8);
        @(negedge clk);
        check_eq("timeout_sticky", 128'(timeout_o), 128'(1));
        repeat (40) @(posedge clk);
        core_mode = 0;
        core_lat  = 2;
        core_q.push_back(32'h0000_0005);
        push_txn(1'b1, 32'h0000_0300, 32'h0, 32'h0000_0005, 32'h0, 32'h0000_0005, 1'b1, 1'b0, 0);
        req(1'b1, 32'h0000_0300, 32'h0, 32'h0000_0005, 32'h0);
        wait_resp(9);
`else
        // Core never drops ready: scheduler parks in WAIT_START
        core_mode = 1;
        push_txn(1'b0, 32'h0000_0077, 32'h0, CACHE_CMD, CACHE_CMDTP, 32'h0, 1'b0, 1'b0, 0);
        req(1'b0, 32'h0000_0077, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(negedge clk);
            check_eq("busy_stuck", 128'(busy_o), 128'(1));
        end
        check_eq("no_resp_stuck", 128'(n_resp), 128'(7));
        do_reset(1);
        core_mode = 0;
        repeat (2) @(posedge clk);
`endif

        // Reset in WAIT_DONE: no response, even when the core finishes later
        begin
            int prev_resp;
            prev_resp = n_resp;
            core_mode = 0;
            core_lat  = 20;
            push_txn(1'b1, 32'h0000_0400, 32'h1111_2222, 32'h0000_0002, 32'h0, 32'h0, 1'b0, 1'b0, 0);
            req(1'b1, 32'h0000_0400, 32'h1111_2222, 32'h0000_0002, 32'h0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            check_eq("busy_before_reset", 128'(busy_o), 128'(1));
            do_reset(1);
            @(negedge clk);
            check_all_zero("mid_reset");
            repeat (40) @(posedge clk);
            check_eq("no_resp_after_reset", 128'(n_resp), 128'(prev_resp));
            check_eq("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
